ifetch_ctrl: RTL and testbench

- Sequential fetch front end that owns the architectural PC register and drives the instruction-memory request/response handshake.
- Presents each fetched instruction with its PC to decode.
- Returns `pc` to the combinational next-PC logic and consumes its `next_pc` result when decode accepts the instruction.
- Non-speculative: at most one instruction outstanding, so branch/jump redirection is implicit.

---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/ifetch_timeout.sv | 37 +++
 rtl/ifetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_ifetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the instruction fetch front end.
//   fetch_state_e   - fetch FSM encoding (IDLE, REQ, WAIT, ISSUE, FAULT)
//   XLEN_DEF        - default address/instruction width
//   RESET_PC_DEF    - default fetch address after reset
//   RSP_TIMEOUT_DEF - default response timeout in WAIT cycles
//   TIMEOUT_W       - timer width for the default timeout
//   timeout_width() - timer width for an arbitrary timeout limit
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ISSUE,
        FAULT
    } fetch_state_e;

    localparam int unsigned          XLEN_DEF        = 32;
    localparam logic [XLEN_DEF-1:0]  RESET_PC_DEF    = 32'h0000_0000;
    localparam int unsigned          RSP_TIMEOUT_DEF = 255;
    localparam int unsigned          TIMEOUT_W       = $clog2(RSP_TIMEOUT_DEF + 1);

    function automatic int unsigned timeout_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ifetch_timeout.sv
// ifetch_timeout: response-wait timer for the fetch FSM.
// Counts up while enabled and saturates at LIMIT; expired_o is high while the
// count equals LIMIT. clear_i has priority over en_i.
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - synchronous active-low reset (count -> 0)
//   clear_i   - restart the count at 0
//   en_i      - advance the count by one
//   expired_o - count has reached LIMIT
module ifetch_timeout
    import ifetch_pkg::*;
#(
    parameter int unsigned LIMIT = RSP_TIMEOUT_DEF,
    parameter int unsigned WIDTH = TIMEOUT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WIDTH-1:0] count_q;

    assign expired_o = (count_q == WIDTH'(LIMIT));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: non-speculative instruction fetch front end.
// Owns the architectural PC, issues one instruction-memory request at a time,
// holds the returned word for decode and takes the successor PC from the
// external next-PC logic on the decode handshake.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (misaligned next_pc or
// RESET_PC raises fetch_err and parks the FSM in FAULT instead of fetching).
// Ports:
//   clk            - clock, rising edge
//   reset          - synchronous active-low reset (0 = reset)
//   pc             - PC of the instruction held for decode
//   next_pc        - successor PC, sampled only on instr handshake
//   imem_req_valid - fetch request valid
//   imem_req_ready - memory accepts request
//   imem_addr      - fetch address, stable while imem_req_valid=1
//   imem_rsp_valid - response valid (single-cycle pulse)
//   imem_rsp_data  - instruction word
//   instr_valid    - instruction available to decode
//   instr_ready    - decode accepts instruction
//   instr          - held instruction word
//   fetch_err      - sticky error flag, cleared only by reset
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned      XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC    = RESET_PC_DEF,
    parameter int unsigned      RSP_TIMEOUT = RSP_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic            fetch_err
);

    localparam int unsigned TW = timeout_width(RSP_TIMEOUT);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            req_valid_q;
    logic            instr_valid_q;
    logic            err_q;

    logic            tmo_clear;
    logic            tmo_en;
    logic            tmo_expired;

    // req_valid_q is always 1 in REQ, so acceptance only needs the ready.
    assign tmo_clear = (state_q == REQ) && imem_req_ready;
    assign tmo_en    = (state_q == WAIT);

    ifetch_timeout #(
        .LIMIT (RSP_TIMEOUT),
        .WIDTH (TW)
    ) u_timeout (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (tmo_clear),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                    if (RESET_PC[1:0] != 2'b00) begin
                        state_q <= FAULT;
                        err_q   <= 1'b1;
                    end else
`endif
                    begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    // A response in the expiry cycle still counts as on time.
                    if (imem_rsp_valid) begin
                        state_q       <= ISSUE;
                        instr_q       <= imem_rsp_data;
                        pc_q          <= fetch_pc_q;
                        instr_valid_q <= 1'b1;
                    end else if (tmo_expired) begin
                        state_q <= FAULT;
                        err_q   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        fetch_pc_q    <= next_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
                        if (next_pc[1:0] != 2'b00) begin
                            state_q <= FAULT;
                            err_q   <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    err_q         <= 1'b1;
                end
                default: begin
                    state_q       <= FAULT;
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    err_q         <= 1'b1;
                end
            endcase
        end
    end

    assign pc             = pc_q;
    assign imem_req_valid = req_valid_q;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scoreboard bench for ifetch_ctrl.
// Expected fetch addresses are queued when the bench drives reset release or
// next_pc; expected {pc, instr} pairs are queued when the bench drives a
// memory response. Both are popped and compared when the DUT presents them.
module tb_ifetch_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned T    = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic            fetch_err;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_iss_q[$];

    ifetch_ctrl #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .RSP_TIMEOUT (T)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset === 1'b1 && imem_req_valid === 1'b1 && imem_req_ready === 1'b1)
            acc_cnt <= acc_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_addr(output logic [31:0] a);
        n_assert++;
        assert (exp_addr_q.size() != 0) else begin
            n_fail++;
            $error("FAIL addr_queue observed=empty expected=entry");
        end
        a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hffff_ffff;
    endtask

    task automatic pop_iss(output logic [63:0] e);
        n_assert++;
        assert (exp_iss_q.size() != 0) else begin
            n_fail++;
            $error("FAIL issue_queue observed=empty expected=entry");
        end
        e = (exp_iss_q.size() != 0) ? exp_iss_q.pop_front() : 64'hffff_ffff_ffff_ffff;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_wait", imem_req_valid, 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fetch_err", fetch_err, 0);
    endtask

    // Wait for and accept one request, answer after `delay` WAIT cycles,
    // then keep decode stalled for `hold` cycles. Leaves the DUT in ISSUE.
    task automatic do_fetch(input logic [31:0] data, input int stall,
                            input int delay, input int hold);
        logic [31:0] ea;
        logic [63:0] ei;
        int acc0;
        wait_req();
        pop_addr(ea);
        chk("req_addr", imem_addr, ea);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("req_valid_hold", imem_req_valid, 1);
            chk("req_addr_hold", imem_addr, ea);
        end
        acc0 = acc_cnt;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("req_drop", imem_req_valid, 0);
        chk("wait_no_issue", instr_valid, 0);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("wait_no_issue", instr_valid, 0);
            chk("wait_no_err", fetch_err, 0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_iss_q.push_back({ea, data});
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hbad0_bad0;
        chk("issue_valid", instr_valid, 1);
        chk("issue_no_err", fetch_err, 0);
        chk("accepted_once", 64'(acc_cnt - acc0), 1);
        pop_iss(ei);
        chk("issue_instr", instr, ei[31:0]);
        chk("issue_pc", pc, ei[63:32]);
        for (int i = 0; i < hold; i++) begin
            next_pc = 32'hdead_0000 + 32'(i);
            step();
            chk("hold_instr_valid", instr_valid, 1);
            chk("hold_instr", instr, ei[31:0]);
            chk("hold_pc", pc, ei[63:32]);
            chk("hold_no_req", imem_req_valid, 0);
        end
    endtask

    task automatic handshake(input logic [31:0] npc);
        next_pc     = npc;
        instr_ready = 1'b1;
        exp_addr_q.push_back(npc);
        step();
        instr_ready = 1'b0;
        next_pc     = 32'hdead_beef;
        chk("hs_instr_valid", instr_valid, 0);
        chk("hs_req_valid", imem_req_valid, 1);
    endtask

    initial begin
        logic [31:0] ea;
        int n;
        int acc0;

        reset          = 1'b0;
        next_pc        = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;

        // Reset values.
        step();
        step();
        check_reset_outputs();
        reset = 1'b1;
        exp_addr_q.push_back(32'h0);

        // Zero-wait fetch at 0, then sequential next_pc=4.
        do_fetch(32'h0050_0093, 0, 0, 0);
        handshake(32'h4);

        // Decode stall for 5 cycles, then branch redirect to 0x40.
        do_fetch(32'h1111_0001, 0, 0, 5);
        handshake(32'h40);

        // Memory holds off acceptance for 3 cycles.
        do_fetch(32'h2222_0002, 3, 0, 0);
        handshake(32'h44);

        // Response arrives in the very cycle the timer expires.
        do_fetch(32'h3333_0003, 0, T, 0);
        handshake(32'h80);

        // No response: timeout into FAULT.
        wait_req();
        pop_addr(ea);
        chk("tmo_req_addr", imem_addr, ea);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        n = 0;
        while (fetch_err !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'(T + 1));
        chk("tmo_err", fetch_err, 1);
        chk("tmo_req_valid", imem_req_valid, 0);
        chk("tmo_instr_valid", instr_valid, 0);
        acc0 = acc_cnt;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        repeat (5) step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("fault_err_sticky", fetch_err, 1);
        chk("fault_no_req", imem_req_valid, 0);
        chk("fault_no_issue", instr_valid, 0);
        chk("fault_no_accept", 64'(acc_cnt - acc0), 0);
        reset = 1'b0;
        step();
        check_reset_outputs();
        reset = 1'b1;
        exp_addr_q.push_back(32'h0);
        do_fetch(32'h4444_0004, 0, 0, 0);
        handshake(32'h10);

        // Reset while in WAIT, then a late response during IDLE and REQ.
        wait_req();
        pop_addr(ea);
        chk("late_req_addr", imem_addr, ea);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset = 1'b0;
        step();
        check_reset_outputs();
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0bad_0bad;
        step();
        chk("late_idle_instr_valid", instr_valid, 0);
        chk("late_idle_instr", instr, 0);
        chk("late_req_valid", imem_req_valid, 1);
        chk("late_addr", imem_addr, 32'h0);
        step();
        imem_rsp_valid = 1'b0;
        chk("late_req_instr_valid", instr_valid, 0);
        chk("late_req_instr", instr, 0);
        exp_addr_q.push_back(32'h0);
        do_fetch(32'h5555_0005, 0, 0, 0);

        // Misaligned next_pc.
        next_pc     = 32'h102;
        instr_ready = 1'b1;
        acc0        = acc_cnt;
        step();
        instr_ready = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis_err", fetch_err, 1);
        chk("mis_no_req", imem_req_valid, 0);
        chk("mis_instr_valid", instr_valid, 0);
        imem_req_ready = 1'b1;
        repeat (3) step();
        imem_req_ready = 1'b0;
        chk("mis_no_req_later", imem_req_valid, 0);
        chk("mis_no_accept", 64'(acc_cnt - acc0), 0);
`else
        exp_addr_q.push_back(32'h102);
        chk("mis_no_err", fetch_err, 0);
        chk("mis_instr_valid", instr_valid, 0);
        do_fetch(32'h6666_0006, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
